// File: rtl/uart_tx_framer.sv
// uart_tx_framer
// Serializes bytes from the host holding path onto txd as start, data,
// optional parity and stop bits. Line format is taken from the line control
// register outputs and latched at the start of every frame. Bit timing is
// counted in shared oversampling baud ticks.
//
// Build option: define UART_TX_FIFO_EN for 16-entry FIFO holding storage;
// without it the holding storage is a single register.
module uart_tx_framer #(
  parameter int OSR_A = 16,
  parameter int OSR_B = 13
) (
  input  logic       m_clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  input  logic       osm_sel,
  output logic       txd,
  output logic       tx_busy,
  output logic       tsre
);

  localparam int OSR_MAX = (OSR_A > OSR_B) ? OSR_A : OSR_B;
  // Wide enough to hold two full bit times (longest stop period).
  localparam int CNT_W   = $clog2(2 * OSR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic [1:0]         r_wls;
  logic               r_stb;
  logic               r_pen;
  logic               r_osm;
  logic               r_par_bit;
  logic               r_line;
  logic               r_txd;
  logic               r_tx_ready;

  logic [CNT_W-1:0]   w_osr;
  logic [CNT_W-1:0]   w_osr_last;
  logic [CNT_W-1:0]   w_stop_last;
  logic               w_bit_end;
  logic               w_last_data;
  logic               w_push;
  logic               w_load;
  logic               w_empty;
  logic [7:0]         w_head;
  logic [7:0]         w_mask;
  logic               w_par;
  logic               w_par_bit;

  // ---------------------------------------------------------------------------
  // Bit timing, all derived from the format latched for the current frame.
  // ---------------------------------------------------------------------------
  assign w_osr      = r_osm ? CNT_W'(OSR_B) : CNT_W'(OSR_A);
  assign w_osr_last = w_osr - CNT_W'(1);

  // Last tick index of the stop period: 1, 1.5 (5-bit words) or 2 bit times.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_stop_last = w_osr_last;
    if (r_stb) begin
      if (r_wls == 2'b00) w_stop_last = w_osr + (w_osr >> 1) - CNT_W'(1);
      else                w_stop_last = (w_osr << 1) - CNT_W'(1);
    end
  end

  assign w_bit_end   = baud_tick &&
                       (r_cnt == ((r_state == S_STOP) ? w_stop_last : w_osr_last));
  assign w_last_data = (r_bit_idx == ({1'b0, r_wls} + 3'd4));

  // The shifter takes a byte from IDLE, or straight out of a finishing stop bit.
  assign w_push = tx_valid && r_tx_ready;
  assign w_load = !w_empty &&
                  ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  // ---------------------------------------------------------------------------
  // Holding storage
  // ---------------------------------------------------------------------------
`ifdef UART_TX_FIFO_EN
  logic [7:0] r_mem [16];
  logic [3:0] r_wr_ptr;
  logic [3:0] r_rd_ptr;
  logic [4:0] r_count;
  logic [4:0] w_count_next;

  assign w_empty = (r_count == 5'd0);
  assign w_head  = r_mem[r_rd_ptr];

  // Occupancy after this cycle's push and pop.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_load})
      2'b10:   w_count_next = r_count + 5'd1;
      2'b01:   w_count_next = r_count - 5'd1;
      default: w_count_next = r_count;
    endcase
  end

  // FIFO storage write.
  // NOTE: the array is not reset; pointers and count alone say which entries are live.
  always_ff @(posedge m_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  // FIFO pointers, occupancy and registered ready (~full).
  always_ff @(posedge m_clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 4'd1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 4'd1;
      r_count    <= w_count_next;
      r_tx_ready <= (w_count_next != 5'd16);
    end
  end
`else
  logic       r_hold_full;
  logic [7:0] r_hold_data;
  logic       w_full_next;

  assign w_empty     = !r_hold_full;
  assign w_head      = r_hold_data;
  // A push needs an empty register and a load needs a full one, so they never overlap.
  assign w_full_next = w_push || (r_hold_full && !w_load);

  // Holding register data capture.
  always_ff @(posedge m_clk) begin
    if (w_push) r_hold_data <= tx_data;
  end

  // Holding register occupancy and registered ready (~full).
  always_ff @(posedge m_clk) begin
    if (reset) begin
      r_hold_full <= 1'b0;
      r_tx_ready  <= 1'b1;
    end else begin
      r_hold_full <= w_full_next;
      r_tx_ready  <= !w_full_next;
    end
  end
`endif

  // Parity of the outgoing word, resolved when the byte is loaded.
  always_comb begin
    w_mask = 8'hFF;
    case (WLS)
      2'b00:   w_mask = 8'h1F;
      2'b01:   w_mask = 8'h3F;
      2'b10:   w_mask = 8'h7F;
      default: w_mask = 8'hFF;
    endcase
  end
  assign w_par     = ^(w_head & w_mask);
  assign w_par_bit = SP ? !EPS : (EPS ? w_par : !w_par);

  // ---------------------------------------------------------------------------
  // Frame sequencer: state, tick counter, shifter and the registered line.
  // ---------------------------------------------------------------------------
  // Walks START/DATA/PARITY/STOP, latching the format at each START entry.
  always_ff @(posedge m_clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_wls     <= '0;
      r_stb     <= 1'b0;
      r_pen     <= 1'b0;
      r_osm     <= 1'b0;
      r_par_bit <= 1'b0;
      r_line    <= 1'b1;
      r_txd     <= 1'b1;
    end else begin
      // NOTE: the last non-blocking assignment to a register in a block wins,
      // so the default here and the break override at the end bracket the FSM.
      r_txd <= r_line;
      if (w_load) begin
        r_state   <= S_START;
        r_shift   <= w_head;
        r_wls     <= WLS;
        r_stb     <= STB;
        r_pen     <= PEN;
        r_osm     <= osm_sel;
        r_par_bit <= w_par_bit;
        r_cnt     <= '0;
        r_bit_idx <= '0;
        r_line    <= 1'b0;
        r_txd     <= 1'b0;
      end else if (r_state != S_IDLE) begin
        if (w_bit_end) begin
          r_cnt <= '0;
          case (r_state)
            S_START: begin
              r_state <= S_DATA;
              r_line  <= r_shift[0];
              r_txd   <= r_shift[0];
            end
            S_DATA: begin
              if (w_last_data) begin
                if (r_pen) begin
                  r_state <= S_PARITY;
                  r_line  <= r_par_bit;
                  r_txd   <= r_par_bit;
                end else begin
                  r_state <= S_STOP;
                  r_line  <= 1'b1;
                  r_txd   <= 1'b1;
                end
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_shift   <= r_shift >> 1;
                r_line    <= r_shift[1];
                r_txd     <= r_shift[1];
              end
            end
            S_PARITY: begin
              r_state <= S_STOP;
              r_line  <= 1'b1;
              r_txd   <= 1'b1;
            end
            default: begin
              // End of stop with nothing waiting: return to idle.
              r_state <= S_IDLE;
              r_line  <= 1'b1;
              r_txd   <= 1'b1;
            end
          endcase
        end else if (baud_tick) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (BC) r_txd <= 1'b0;
    end
  end

  assign txd      = r_txd;
  assign tx_ready = r_tx_ready;
  assign tx_busy  = (r_state != S_IDLE);
  assign tsre     = w_empty && (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer. A frame-level model expands each accepted
// byte into (level, tick count) segments and predicts txd, tx_ready, tx_busy
// and tsre every cycle; directed tests add hand-computed literal checks.
module tb_uart_tx_framer;

  localparam int OSR_A = 16;
  localparam int OSR_B = 13;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1;
`endif

  logic       m_clk     = 1'b0;
  logic       reset     = 1'b1;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       tx_ready;
  logic [1:0] WLS       = 2'b11;
  logic       STB       = 1'b0;
  logic       PEN       = 1'b0;
  logic       EPS       = 1'b0;
  logic       SP        = 1'b0;
  logic       BC        = 1'b0;
  logic       osm_sel   = 1'b0;
  logic       txd;
  logic       tx_busy;
  logic       tsre;

  int n_checks = 0;
  int n_errors = 0;
  int tick_div = 1;
  bit cmp_en   = 1'b0;
  bit cap [4096];

  uart_tx_framer #(.OSR_A(OSR_A), .OSR_B(OSR_B)) dut (
    .m_clk    (m_clk),
    .reset    (reset),
    .baud_tick(baud_tick),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .WLS      (WLS),
    .STB      (STB),
    .PEN      (PEN),
    .EPS      (EPS),
    .SP       (SP),
    .BC       (BC),
    .osm_sel  (osm_sel),
    .txd      (txd),
    .tx_busy  (tx_busy),
    .tsre     (tsre)
  );

  always #5 m_clk = ~m_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Baud tick: one pulse every tick_div cycles (tick_div=1 means stuck high).
  initial begin
    int ph = 0;
    forever begin
      @(negedge m_clk);
      ph = (ph + 1) % tick_div;
      baud_tick = (ph == 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-level model
  // ---------------------------------------------------------------------------
  logic [7:0] q_pend [$];
  bit         m_active = 1'b0;
  bit         seg_lvl [16];
  int         seg_len [16];
  int         nseg  = 0;
  int         sidx  = 0;
  int         sleft = 0;
  logic       m_txd   = 1'b1;
  logic       m_ready = 1'b1;
  logic       m_busy  = 1'b0;
  logic       m_tsre  = 1'b1;

  function automatic void start_frame();
    logic [7:0] b;
    int osr;
    int n;
    bit p;
    b   = q_pend.pop_front();
    osr = osm_sel ? OSR_B : OSR_A;
    n   = 5 + int'(WLS);
    p   = 1'b0;
    nseg = 0;
    seg_lvl[nseg] = 1'b0; seg_len[nseg] = osr; nseg++;
    for (int i = 0; i < n; i++) begin
      seg_lvl[nseg] = b[i]; seg_len[nseg] = osr; nseg++;
      p ^= b[i];
    end
    if (PEN) begin
      seg_lvl[nseg] = SP ? !EPS : (EPS ? p : !p); seg_len[nseg] = osr; nseg++;
    end
    seg_lvl[nseg] = 1'b1;
    seg_len[nseg] = !STB ? osr : ((WLS == 2'b00) ? osr + osr / 2 : 2 * osr);
    nseg++;
    sidx     = 0;
    sleft    = seg_len[0];
    m_active = 1'b1;
  endfunction

  task automatic model_step();
    logic ready_pre;
    if (reset) begin
      q_pend.delete();
      m_active = 1'b0;
      m_ready  = 1'b1;
      m_txd    = 1'b1;
    end else begin
      ready_pre = m_ready;
      if (m_active) begin
        if (baud_tick) begin
          sleft--;
          if (sleft == 0) begin
            sidx++;
            if (sidx == nseg) begin
              m_active = 1'b0;
              if (q_pend.size() > 0) start_frame();
            end else begin
              sleft = seg_len[sidx];
            end
          end
        end
      end else if (q_pend.size() > 0) begin
        start_frame();
      end
      if (tx_valid && ready_pre) q_pend.push_back(tx_data);
      m_ready = (q_pend.size() < DEPTH);
      m_txd   = BC ? 1'b0 : (m_active ? seg_lvl[sidx] : 1'b1);
    end
    m_busy = m_active;
    m_tsre = !m_active && (q_pend.size() == 0);
  endtask

  initial forever begin
    @(posedge m_clk);
    model_step();
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge m_clk);
    if (cmp_en) begin
      check("cyc_txd",      txd,      m_txd);
      check("cyc_tx_ready", tx_ready, m_ready);
      check("cyc_tx_busy",  tx_busy,  m_busy);
      check("cyc_tsre",     tsre,     m_tsre);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_cfg(input logic [1:0] wls, input logic pen, input logic eps,
                         input logic sp, input logic stb, input logic osm);
    @(negedge m_clk);
    WLS = wls; PEN = pen; EPS = eps; SP = sp; STB = stb; osm_sel = osm;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge m_clk);
    tx_valid = 1'b1;
    tx_data  = b;
    while (tx_ready !== 1'b1 && n < 5000) begin
      @(negedge m_clk);
      n++;
    end
    check("send_ready_wait", n < 5000, 1);
    @(posedge m_clk);
    @(negedge m_clk);
    tx_valid = 1'b0;
  endtask

  // Records txd at every cycle tx_busy is high; dur = number of busy cycles.
  task automatic capture(output int dur);
    int n = 0;
    dur = 0;
    @(negedge m_clk);
    while (tx_busy !== 1'b1 && n < 200) begin
      @(negedge m_clk);
      n++;
    end
    check("capture_start_wait", n < 200, 1);
    while (tx_busy === 1'b1 && dur < 4000) begin
      cap[dur] = txd;
      dur++;
      @(negedge m_clk);
    end
  endtask

  task automatic run_frame(input logic [7:0] b, output int dur);
    int d = 0;
    fork
      send(b);
      capture(d);
    join
    dur = d;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(tsre === 1'b1 && tx_busy === 1'b0) && n < budget) begin
      @(negedge m_clk);
      n++;
    end
    check("idle_wait", n < budget, 1);
  endtask

  function automatic bit bit_at(input int base, input int k, input int osr);
    return cap[base + k * osr + osr / 2];
  endfunction

  function automatic logic [7:0] decode(input int base, input int n, input int osr);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = cap[base + (i + 1) * osr + osr / 2];
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int dur;
    logic [9:0] v;

    reset = 1'b1;
    repeat (3) @(negedge m_clk);
    cmp_en = 1'b1;
    reset  = 1'b0;
    @(negedge m_clk);
    check("rst_txd",      txd,      1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_busy",  tx_busy,  0);
    check("rst_tsre",     tsre,     1);

    // 8N1, 0x55: alternating line, 16 cycles per bit with the tick stuck high.
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(8'h55, dur);
    check("8n1_dur", dur, 160);
    for (int k = 0; k < 10; k++) v[k] = bit_at(0, k, 16);
    check("8n1_bits", v, 10'b1010101010);
    check("8n1_tsre_after", tsre, 1);
    check("8n1_txd_after",  txd,  1);

    // 7E1, 0x41: data 1000001 LSB first, even parity 0; odd parity 1.
    set_cfg(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(8'h41, dur);
    check("7e1_dur",    dur, 160);
    check("7e1_data",   decode(0, 7, 16), 8'h41);
    check("7e1_parity", bit_at(0, 8, 16), 0);
    set_cfg(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(8'h41, dur);
    check("7o1_parity", bit_at(0, 8, 16), 1);

    // 5-bit with STB=1: 1.5 stop bits (24 ticks); 6-bit: 2 stop bits (32 ticks).
    set_cfg(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(8'h1F, dur);
    check("5b_stb_dur",  dur, 120);
    check("5b_stb_data", decode(0, 5, 16), 8'h1F);
    set_cfg(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(8'h1F, dur);
    check("6b_stb_dur",  dur, 144);

    // Stick parity on 8-bit 0xFF: EPS=1 -> 0, EPS=0 -> 1; OSR_B gives 13 ticks/bit.
    set_cfg(2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(8'hFF, dur);
    check("stick1_dur",    dur, 176);
    check("stick1_parity", bit_at(0, 9, 16), 0);
    set_cfg(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(8'hFF, dur);
    check("stick0_parity", bit_at(0, 9, 16), 1);
    set_cfg(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    run_frame(8'hFF, dur);
    check("osr13_dur",    dur, 143);
    check("osr13_parity", bit_at(0, 9, 13), 1);
    check("osr13_start",  bit_at(0, 0, 13), 0);

    // Back-to-back 0xA5, 0x3C: busy never drops between frames.
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fork
      begin send(8'hA5); send(8'h3C); end
      capture(dur);
    join
    check("b2b_dur",      dur, 320);
    check("b2b_data0",    decode(0, 8, 16), 8'hA5);
    check("b2b_stop0",    cap[159], 1);
    check("b2b_start1",   bit_at(160, 0, 16), 0);
    check("b2b_data1",    decode(160, 8, 16), 8'h3C);

    // Break in the middle of DATA forces the line low; frame timing unchanged.
    fork
      send(8'hFF);
      capture(dur);
      begin
        int n = 0;
        while (tx_busy !== 1'b1 && n < 200) begin @(negedge m_clk); n++; end
        repeat (40) @(negedge m_clk);
        BC = 1'b1;
        @(negedge m_clk);
        check("bc_txd_low", txd, 0);
        repeat (10) @(negedge m_clk);
        check("bc_txd_held", txd, 0);
        BC = 1'b0;
        @(negedge m_clk);
        check("bc_txd_resume", txd, 1);
      end
    join
    check("bc_dur", dur, 160);
    wait_idle(100);

    // Reset in DATA with a second byte waiting: line idles and storage flushes.
    send(8'hFF);
    send(8'h00);
    repeat (40) @(negedge m_clk);
    reset = 1'b1;
    @(negedge m_clk);
    check("midrst_txd",  txd,     1);
    check("midrst_busy", tx_busy, 0);
    check("midrst_tsre", tsre,    1);
    reset = 1'b0;
    repeat (30) @(negedge m_clk);
    check("midrst_flushed", tx_busy, 0);

    // Sparse ticks (every 3rd cycle), 6O1 with 2 stop bits; format change mid-frame
    // must not affect the frame already started.
    tick_div = 3;
    set_cfg(2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h2A);
    begin
      int n = 0;
      while (tx_busy !== 1'b1 && n < 200) begin @(negedge m_clk); n++; end
      check("sparse_start_wait", n < 200, 1);
    end
    repeat (20) @(negedge m_clk);
    WLS = 2'b11;
    wait_idle(3000);
    tick_div = 1;

`ifdef UART_TX_FIFO_EN
    // FIFO fill: 17 accepts (one goes straight to the shifter) before ready drops.
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    begin
      int acc = 0;
      int n   = 0;
      @(negedge m_clk);
      tx_valid = 1'b1;
      tx_data  = 8'h80;
      while (tx_ready === 1'b1 && n < 100) begin
        @(posedge m_clk);
        acc++;
        @(negedge m_clk);
        tx_data = 8'(acc + 128);
        n++;
      end
      tx_valid = 1'b0;
      check("fifo_accepts",  acc,      17);
      check("fifo_ready",    tx_ready, 0);
      check("fifo_shifting", tx_busy,  1);
    end
    wait_idle(4000);
`else
    // Single holding register: ready drops after an accept while a frame is shifting.
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h11);
    send(8'h22);
    check("hold_ready_low", tx_ready, 0);
    check("hold_busy",      tx_busy,  1);
    wait_idle(1000);
`endif

    repeat (5) @(negedge m_clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
